ntt_poly_scheduler: RTL and testbench

Polynomial-granularity scheduler in front of the NTT pipeline input. It arbitrates two polynomial sources (e.g. forward-NTT operand buffer and key-switch buffer) round-robin, one whole polynomial per grant. It owns the pipeline length configuration (`MAX_LEN` or `MAX_LEN/2`). When the next polynomial needs a different length, it drains the pipeline before switching.

---
 rtl/ntt_poly_scheduler_if.sv | 58 +++++
 rtl/ntt_poly_scheduler.sv | 154 +++++++++++++++
 tb/tb_ntt_poly_scheduler.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ntt_poly_scheduler_if.sv
// Bundles the source-buffer side and the NTT-input side of ntt_poly_scheduler.
// The scheduler takes the slave modport; the environment (buffers + NTT stage) drives master.
interface ntt_poly_scheduler_if #(
    parameter int MAX_LEN = 1024,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = $clog2(MAX_LEN) - 1,
    parameter int TAG_W   = 16
);
    // source side
    logic [1:0]        req_empty;
    logic [LEN_W-1:0]  req_len0;
    logic [LEN_W-1:0]  req_len1;
    logic [DATA_W-1:0] req_dA0;
    logic [DATA_W-1:0] req_dB0;
    logic [DATA_W-1:0] req_dA1;
    logic [DATA_W-1:0] req_dB1;
    logic [TAG_W-1:0]  req_tag0;
    logic [TAG_W-1:0]  req_tag1;
    logic [ADDR_W-1:0] req_addrA;
    logic [ADDR_W-1:0] req_addrB;
    logic [1:0]        req_rd_finish;

    // NTT side
    logic              ntt_empty;
    logic [DATA_W-1:0] ntt_dA;
    logic [DATA_W-1:0] ntt_dB;
    logic [TAG_W-1:0]  ntt_tag;
    logic [ADDR_W-1:0] ntt_addrA;
    logic [ADDR_W-1:0] ntt_addrB;
    logic              ntt_rd_finish;
    logic              ntt_idle;

    // configuration / status
    logic [LEN_W-1:0]  cfg_length;
    logic [1:0]        grant;
    logic              err_len;

    modport slave (
        input  req_empty, req_len0, req_len1,
        input  req_dA0, req_dB0, req_dA1, req_dB1,
        input  req_tag0, req_tag1,
        output req_addrA, req_addrB, req_rd_finish,
        output ntt_empty, ntt_dA, ntt_dB, ntt_tag,
        input  ntt_addrA, ntt_addrB, ntt_rd_finish, ntt_idle,
        output cfg_length, grant, err_len
    );

    modport master (
        output req_empty, req_len0, req_len1,
        output req_dA0, req_dB0, req_dA1, req_dB1,
        output req_tag0, req_tag1,
        input  req_addrA, req_addrB, req_rd_finish,
        input  ntt_empty, ntt_dA, ntt_dB, ntt_tag,
        output ntt_addrA, ntt_addrB, ntt_rd_finish, ntt_idle,
        input  cfg_length, grant, err_len
    );
endinterface

// File: rtl/ntt_poly_scheduler.sv
// Round-robin polynomial scheduler in front of the NTT pipeline; drains the pipeline before
// changing cfg_length. Optional macro NTT_SCHED_LEN_CHECK_EN discards illegal-length polynomials.
module ntt_poly_scheduler #(
    parameter int MAX_LEN = 1024,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1,
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = $clog2(MAX_LEN) - 1,
    parameter int TAG_W   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    ntt_poly_scheduler_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_LEN);

    logic [1:0]        state;
    logic              sel;
    logic              last;
    logic [LEN_W-1:0]  pend_len;
    logic [LEN_W-1:0]  cfg_length;
    logic [1:0]        grant;

    logic [1:0]        ready;
    logic              any_ready;
    logic              pick;
    logic [LEN_W-1:0]  pick_len;
    logic              len_ok;
    logic              discard;
    logic              finish;
    logic              data_sel;

    logic [DATA_W-1:0] mux_dA;
    logic [DATA_W-1:0] mux_dB;
    logic [TAG_W-1:0]  mux_tag;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [1:0]        rd_finish;
    logic              ntt_empty;

    // Arbitration: when both sources are ready the one not granted last wins.
    always_comb begin
        ready     = ~bus.req_empty;
        any_ready = |ready;
        pick      = 1'b0;
        if (ready == 2'b11) begin
            pick = ~last;
        end else begin
            pick = ready[1];
        end
        pick_len = pick ? bus.req_len1 : bus.req_len0;
    end

`ifdef NTT_SCHED_LEN_CHECK_EN
    localparam logic [LEN_W-1:0] HALF_LEN = LEN_W'(MAX_LEN / 2);
    logic err_q;

    assign len_ok = (pick_len == FULL_LEN) || (pick_len == HALF_LEN);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (discard) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_len = err_q;
`else
    assign len_ok      = 1'b1;
    assign bus.err_len = 1'b0;
`endif

    assign discard = (state == ST_IDLE) && any_ready && !len_ok;
    assign finish  = (state == ST_STREAM) && bus.ntt_rd_finish;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            sel        <= 1'b0;
            last       <= 1'b1;
            pend_len   <= FULL_LEN;
            cfg_length <= FULL_LEN;
            grant      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_ready) begin
                        if (!len_ok) begin
                            // discarded polynomial still counts as a turn for round-robin
                            last <= pick;
                        end else begin
                            sel      <= pick;
                            pend_len <= pick_len;
                            grant    <= {pick, ~pick};
                            state    <= (pick_len == cfg_length) ? ST_STREAM : ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.ntt_idle) begin
                        state <= ST_SWITCH;
                    end
                end
                ST_SWITCH: begin
                    cfg_length <= pend_len;
                    state      <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (bus.ntt_rd_finish) begin
                        last  <= sel;
                        grant <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Data path follows source 0 whenever no grant is held.
    always_comb begin
        data_sel  = sel & (|grant);
        mux_dA    = data_sel ? bus.req_dA1  : bus.req_dA0;
        mux_dB    = data_sel ? bus.req_dB1  : bus.req_dB0;
        mux_tag   = data_sel ? bus.req_tag1 : bus.req_tag0;
        addr_a    = bus.ntt_addrA;
        addr_b    = bus.ntt_addrB;
        ntt_empty = 1'b1;
        if (state == ST_STREAM) begin
            ntt_empty = bus.req_empty[sel];
        end
        rd_finish = '0;
        if (finish) begin
            rd_finish = {sel, ~sel};
        end else if (discard) begin
            rd_finish = {pick, ~pick};
        end
    end

    assign bus.req_addrA     = addr_a;
    assign bus.req_addrB     = addr_b;
    assign bus.req_rd_finish = rd_finish;
    assign bus.ntt_empty     = ntt_empty;
    assign bus.ntt_dA        = mux_dA;
    assign bus.ntt_dB        = mux_dB;
    assign bus.ntt_tag       = mux_tag;
    assign bus.cfg_length    = cfg_length;
    assign bus.grant         = grant;
endmodule

// File: tb/tb_ntt_poly_scheduler.sv
// Directed table-driven bench for ntt_poly_scheduler plus hand sequences for drain,
// async reset and the length-check option (NTT_SCHED_LEN_CHECK_EN).
module tb_ntt_poly_scheduler;
    localparam int MAX_LEN = 1024;
    localparam int LEN_W   = 11;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 9;
    localparam int TAG_W   = 16;

    localparam logic [LEN_W-1:0] L = 11'd1024;
    localparam logic [LEN_W-1:0] H = 11'd512;

    localparam logic [DATA_W-1:0] DA0 = 64'hA0A0_0000_0000_00A0;
    localparam logic [DATA_W-1:0] DB0 = 64'hB0B0_0000_0000_00B0;
    localparam logic [DATA_W-1:0] DA1 = 64'hA1A1_1111_1111_11A1;
    localparam logic [DATA_W-1:0] DB1 = 64'hB1B1_1111_1111_11B1;
    localparam logic [TAG_W-1:0]  TG0 = 16'h0123;
    localparam logic [TAG_W-1:0]  TG1 = 16'h4567;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ntt_poly_scheduler_if #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)
    ) bus ();

    ntt_poly_scheduler #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]       empty;
        logic [LEN_W-1:0] len0;
        logic [LEN_W-1:0] len1;
        logic             idle;
        logic             fin;
        logic [1:0]       grant;
        logic             nempty;
        logic [LEN_W-1:0] cfg;
        logic [1:0]       rdf;
        logic             src;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] e, input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1,
                         input logic idle, input logic fin);
        bus.req_empty     = e;
        bus.req_len0      = l0;
        bus.req_len1      = l1;
        bus.ntt_idle      = idle;
        bus.ntt_rd_finish = fin;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] g, input logic ne,
                           input logic [LEN_W-1:0] cfg, input logic [1:0] rdf);
        chk({tag, ".grant"}, 64'(bus.grant), 64'(g));
        chk({tag, ".ntt_empty"}, 64'(bus.ntt_empty), 64'(ne));
        chk({tag, ".cfg_length"}, 64'(bus.cfg_length), 64'(cfg));
        chk({tag, ".req_rd_finish"}, 64'(bus.req_rd_finish), 64'(rdf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_empty     = 2'b11;
        bus.req_len0      = L;
        bus.req_len1      = L;
        bus.req_dA0       = DA0;
        bus.req_dB0       = DB0;
        bus.req_dA1       = DA1;
        bus.req_dB1       = DB1;
        bus.req_tag0      = TG0;
        bus.req_tag1      = TG1;
        bus.ntt_addrA     = 9'h055;
        bus.ntt_addrB     = 9'h1AA;
        bus.ntt_rd_finish = 1'b0;
        bus.ntt_idle      = 1'b1;

        //            empty  len0 len1 idle fin  grant  ne  cfg rdf   src
        tbl[0]  = '{2'b11, L, L, 1'b1, 1'b0, 2'b00, 1'b1, L, 2'b00, 1'b0};
        tbl[1]  = '{2'b10, L, L, 1'b1, 1'b0, 2'b00, 1'b1, L, 2'b00, 1'b0};
        tbl[2]  = '{2'b10, L, L, 1'b1, 1'b0, 2'b01, 1'b0, L, 2'b00, 1'b0};
        tbl[3]  = '{2'b10, L, L, 1'b1, 1'b1, 2'b01, 1'b0, L, 2'b01, 1'b0};
        tbl[4]  = '{2'b11, L, L, 1'b1, 1'b0, 2'b00, 1'b1, L, 2'b00, 1'b0};
        tbl[5]  = '{2'b00, L, L, 1'b1, 1'b0, 2'b00, 1'b1, L, 2'b00, 1'b0};
        tbl[6]  = '{2'b00, L, L, 1'b1, 1'b0, 2'b10, 1'b0, L, 2'b00, 1'b1};
        tbl[7]  = '{2'b00, L, L, 1'b1, 1'b1, 2'b10, 1'b0, L, 2'b10, 1'b1};
        tbl[8]  = '{2'b00, L, L, 1'b1, 1'b0, 2'b00, 1'b1, L, 2'b00, 1'b0};
        tbl[9]  = '{2'b00, L, L, 1'b1, 1'b1, 2'b01, 1'b0, L, 2'b01, 1'b0};
        tbl[10] = '{2'b01, L, L, 1'b1, 1'b0, 2'b00, 1'b1, L, 2'b00, 1'b0};
        tbl[11] = '{2'b01, L, L, 1'b1, 1'b0, 2'b10, 1'b0, L, 2'b00, 1'b1};
        tbl[12] = '{2'b11, L, L, 1'b1, 1'b1, 2'b10, 1'b1, L, 2'b10, 1'b1};
        tbl[13] = '{2'b11, L, L, 1'b1, 1'b0, 2'b00, 1'b1, L, 2'b00, 1'b0};
        tbl[14] = '{2'b11, L, L, 1'b1, 1'b1, 2'b00, 1'b1, L, 2'b00, 1'b0};
        tbl[15] = '{2'b01, L, H, 1'b0, 1'b0, 2'b00, 1'b1, L, 2'b00, 1'b0};
        tbl[16] = '{2'b01, L, H, 1'b0, 1'b1, 2'b10, 1'b1, L, 2'b00, 1'b1};

        // reset state
        #12;
        chk_out("reset", 2'b00, 1'b1, L, 2'b00);
        chk("reset.err_len", 64'(bus.err_len), 64'd0);
        chk("reset.ntt_dA", bus.ntt_dA, DA0);
        rstn = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc();
            drive(tbl[i].empty, tbl[i].len0, tbl[i].len1, tbl[i].idle, tbl[i].fin);
            chk_out($sformatf("vec%0d", i), tbl[i].grant, tbl[i].nempty, tbl[i].cfg, tbl[i].rdf);
            chk($sformatf("vec%0d.ntt_dA", i), bus.ntt_dA, tbl[i].src ? DA1 : DA0);
            chk($sformatf("vec%0d.ntt_dB", i), bus.ntt_dB, tbl[i].src ? DB1 : DB0);
            chk($sformatf("vec%0d.ntt_tag", i), 64'(bus.ntt_tag), 64'(tbl[i].src ? TG1 : TG0));
            chk($sformatf("vec%0d.req_addrA", i), 64'(bus.req_addrA), 64'h055);
            chk($sformatf("vec%0d.req_addrB", i), 64'(bus.req_addrB), 64'h1AA);
        end

        // long drain: pipeline stays busy, grant held with ntt_empty=1
        for (int i = 0; i < 19; i++) begin
            cyc();
            drive(2'b01, L, H, 1'b0, 1'b0);
            chk_out($sformatf("drain%0d", i), 2'b10, 1'b1, L, 2'b00);
        end
        cyc();
        drive(2'b01, L, H, 1'b1, 1'b0);
        chk_out("drain_idle_rise", 2'b10, 1'b1, L, 2'b00);
        cyc();
        drive(2'b01, L, H, 1'b1, 1'b1);
        chk_out("switch", 2'b10, 1'b1, L, 2'b00);
        cyc();
        drive(2'b01, L, H, 1'b1, 1'b1);
        chk_out("stream_512", 2'b10, 1'b0, H, 2'b10);
        cyc();
        drive(2'b10, H, H, 1'b1, 1'b0);
        chk_out("idle_after_512", 2'b00, 1'b1, H, 2'b00);
        cyc();
        drive(2'b10, H, H, 1'b1, 1'b0);
        chk_out("stream_match_512", 2'b01, 1'b0, H, 2'b00);

        // asynchronous reset in the middle of STREAM
        #1;
        bus.ntt_rd_finish = 1'b1;
        rstn = 1'b0;
        #1;
        chk_out("async_rst", 2'b00, 1'b1, L, 2'b00);
        drive(2'b00, L, L, 1'b1, 1'b0);
        cyc();
        #2;
        rstn = 1'b1;
        cyc();
        drive(2'b00, L, L, 1'b1, 1'b0);
        chk_out("post_rst_grant", 2'b01, 1'b0, L, 2'b00);
        chk("post_rst.ntt_tag", 64'(bus.ntt_tag), 64'(TG0));
        drive(2'b00, L, L, 1'b1, 1'b1);
        chk("post_rst.rdf", 64'(bus.req_rd_finish), 64'b01);
        cyc();
        drive(2'b11, L, L, 1'b1, 1'b0);
        chk_out("post_rst_idle", 2'b00, 1'b1, L, 2'b00);

        // illegal length on source 0
        cyc();
        drive(2'b10, 11'd300, L, 1'b1, 1'b0);
`ifdef NTT_SCHED_LEN_CHECK_EN
        chk_out("len300_discard", 2'b00, 1'b1, L, 2'b01);
        chk("len300.err_pre", 64'(bus.err_len), 64'd0);
        cyc();
        drive(2'b11, L, L, 1'b1, 1'b0);
        chk_out("len300_after", 2'b00, 1'b1, L, 2'b00);
        chk("len300.err_set", 64'(bus.err_len), 64'd1);
        cyc();
        drive(2'b11, L, L, 1'b1, 1'b0);
        chk("len300.err_sticky", 64'(bus.err_len), 64'd1);
        chk("len300.grant", 64'(bus.grant), 64'b00);
`else
        chk_out("len300_idle", 2'b00, 1'b1, L, 2'b00);
        cyc();
        drive(2'b10, 11'd300, L, 1'b1, 1'b0);
        chk_out("len300_drain", 2'b01, 1'b1, L, 2'b00);
        cyc();
        drive(2'b10, 11'd300, L, 1'b1, 1'b0);
        chk_out("len300_switch", 2'b01, 1'b1, L, 2'b00);
        cyc();
        drive(2'b10, 11'd300, L, 1'b1, 1'b0);
        chk_out("len300_stream", 2'b01, 1'b0, 11'd300, 2'b00);
        chk("len300.err_len", 64'(bus.err_len), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
